// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, state encoding and arctangent table for the CORDIC blocks.
//   Angle scale is radians * 2^14, so 12867 = pi/4, 25736 = pi/2 and 51472 = pi.
//   No ports; imported by vec_atan_rom and cordic_vector.
package cordic_pkg;

    localparam int ANGLE_FRAC = 14;
    localparam int HALF_PI    = 25736;
    localparam int PI         = 51472;
    localparam int ATAN_DEPTH = 14;

    // Magnitude growth of the full 14-step rotation chain; documentation only.
    localparam real CORDIC_GAIN = 1.64676;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_DONE
    } state_t;

    // atan(2^-i) in the shared angle scale; indices past the table read as 0.
    function automatic logic [15:0] atan_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_entry = 16'd12867;
            4'd1:    atan_entry = 16'd7596;
            4'd2:    atan_entry = 16'd4013;
            4'd3:    atan_entry = 16'd2037;
            4'd4:    atan_entry = 16'd1022;
            4'd5:    atan_entry = 16'd511;
            4'd6:    atan_entry = 16'd255;
            4'd7:    atan_entry = 16'd127;
            4'd8:    atan_entry = 16'd63;
            4'd9:    atan_entry = 16'd31;
            4'd10:   atan_entry = 16'd15;
            4'd11:   atan_entry = 16'd7;
            4'd12:   atan_entry = 16'd3;
            4'd13:   atan_entry = 16'd1;
            default: atan_entry = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/vec_atan_rom.sv
// vec_atan_rom: registered arctangent table with read enable and one-cycle read latency.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears the output register
//   en    : read enable; data holds its value while low
//   addr  : 4-bit table index
//   data  : atan(2^-addr) in rad * 2^14, zero for addr > 13
module vec_atan_rom
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  addr,
    output logic [15:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            data <= '0;
        else if (en)
            data <= atan_entry(addr);
    end

endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC, (x, y) -> atan2(y, x) and gain-scaled magnitude.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : request, accepted only while in_ready = 1
//   in_ready  : block idle
//   x_in/y_in : signed Cartesian input, DW bits
//   out_valid : one-cycle result strobe
//   angle_out : signed angle in rad * 2^14, range +/-51472
//   mag_out   : magnitude times the CORDIC gain, non-negative
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int ITER = 14,
    parameter int DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] y_in,
    output logic                 out_valid,
    output logic signed [DW+1:0] angle_out,
    output logic signed [DW+1:0] mag_out
);

    localparam int W = DW + 2;

    state_t              state;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic [3:0]          idx;
    logic                zero;
    logic                rom_en;
    logic [3:0]          rom_addr;
    logic [15:0]         atan;
    logic signed [W-1:0] atan_s;
    logic                x_neg;
    logic                y_neg;

    // The table is read one cycle ahead of use: index 0 in PRE, index i+1 while iterating on i.
    assign rom_en   = (state == S_PRE) || (state == S_ITER);
    assign rom_addr = (state == S_ITER) ? idx + 4'd1 : 4'd0;
    assign atan_s   = W'(atan);
    assign x_neg    = x[W-1];
    assign y_neg    = y[W-1];

    vec_atan_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rom_en),
        .addr  (rom_addr),
        .data  (atan)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            idx       <= '0;
            zero      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x        <= W'(x_in);
                        y        <= W'(y_in);
                        zero     <= (x_in == '0) && (y_in == '0);
                        in_ready <= 1'b0;
                        state    <= S_PRE;
                    end
                end
                S_PRE: begin
                    // Left half-plane vectors are turned by -/+90 deg into the right half-plane
                    // so the micro-rotations (which converge only within ~+/-99 deg) can finish.
                    x     <= !x_neg ? x : (!y_neg ? y : -y);
                    y     <= !x_neg ? y : (!y_neg ? -x : x);
                    z     <= !x_neg ? '0 : (!y_neg ? W'(HALF_PI) : -W'(HALF_PI));
                    idx   <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    x     <= y_neg ? x - (y >>> idx) : x + (y >>> idx);
                    y     <= y_neg ? y + (x >>> idx) : y - (x >>> idx);
                    z     <= y_neg ? z - atan_s : z + atan_s;
                    idx   <= idx + 4'd1;
                    state <= (idx == 4'(ITER - 1)) ? S_DONE : S_ITER;
                end
                S_DONE: begin
                    // A zero vector has no defined angle; the rotations would drift z, so force 0.
                    angle_out <= zero ? '0 : z;
                    mag_out   <= zero ? '0 : x;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
